// File: rtl/ddr2_v11_0_p0_qsys_sequencer_rom_loader_pkg.sv
// Shared definitions for the sequencer ROM loader: ROM geometry and FSM state encoding.
package ddr2_v11_0_p0_qsys_sequencer_rom_loader_pkg;

  localparam int ROM_ADDR_WIDTH = 12;
  localparam int ROM_DATA_WIDTH = 32;
  localparam int ROM_DEPTH      = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/ddr2_v11_0_p0_qsys_sequencer_rom_loader.sv
// Loads an image stream into the sequencer ROM through its debug-write port,
// then reads it back and compares additive checksums of written and read data.
module ddr2_v11_0_p0_qsys_sequencer_rom_loader
  import ddr2_v11_0_p0_qsys_sequencer_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int DEPTH      = ROM_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     word_count,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable,
  output logic                    avm_chipselect,
  output logic                    avm_write,
  output logic                    avm_debugaccess,
  output logic [DATA_WIDTH-1:0]   avm_writedata,
  output logic                    avm_clken,
  input  logic [DATA_WIDTH-1:0]   avm_readdata
);

  localparam int CW   = ADDR_WIDTH + 1;
  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  // Handshake: a word transfers in any cycle where in_valid and in_ready are
  // both high; in_ready depends only on state, never on in_valid.

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wsum_q, wsum_d;
  logic [DATA_WIDTH-1:0] rsum_q, rsum_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_cs_q, rd_cs_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  clken_q;

  logic                  wr_fire;
  logic                  last_addr;
  logic [CW-1:0]         start_cnt;
  logic                  sums_match;

  assign in_ready   = (state_q == ST_WRITE);
  assign wr_fire    = in_ready & in_valid;
  assign last_addr  = (addr_q == (cnt_q - CNT_ONE));
  assign start_cnt  = (word_count > CNT_MAX) ? CNT_MAX : word_count;
  assign sums_match = (wsum_q == rsum_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wsum_d    = wsum_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    rd_pend_d = (state_q == ST_READ);
    // Read data returns one cycle after its address, so accumulate on the
    // cycle after every read-address cycle (including the drain cycle).
    rsum_d    = rd_pend_q ? (rsum_q + avm_readdata) : rsum_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d  = start_cnt;
          addr_d = '0;
          wsum_d = '0;
          rsum_d = '0;
          pass_d = 1'b0;
          fail_d = 1'b0;
          if (start_cnt == '0) begin
            pass_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (wr_fire) begin
          wsum_d = wsum_q + in_data;
          if (last_addr) begin
            addr_d  = '0;
            state_d = ST_READ;
          end else begin
            addr_d  = addr_q + CNT_ONE;
          end
        end
      end
      ST_READ: begin
        if (last_addr) begin
          addr_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          addr_d  = addr_q + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        pass_d  = sums_match;
        fail_d  = !sums_match;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_cs_d = (state_d == ST_READ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wsum_q    <= '0;
      rsum_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_cs_q   <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      clken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wsum_q    <= wsum_d;
      rsum_q    <= rsum_d;
      rd_pend_q <= rd_pend_d;
      rd_cs_q   <= rd_cs_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      clken_q   <= 1'b1;
    end
  end

  // Write strobes and data bypass the registers so an accepted word reaches
  // the ROM in the same cycle; read-phase strobes come straight from flops.
  assign avm_chipselect  = wr_fire | rd_cs_q;
  assign avm_write       = wr_fire;
  assign avm_debugaccess = wr_fire;
  assign avm_writedata   = wr_fire ? in_data : '0;
  assign avm_address     = addr_q[ADDR_WIDTH-1:0];
  assign avm_byteenable  = {BE_W{avm_chipselect}};
  assign avm_clken       = clken_q;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign pass = pass_q;
  assign fail = fail_q;

endmodule

// File: tb/tb_ddr2_v11_0_p0_qsys_sequencer_rom_loader.sv
// Self-checking bench for the sequencer ROM loader with a one-cycle-latency ROM model.
module tb_ddr2_v11_0_p0_qsys_sequencer_rom_loader;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [AW:0]     word_count = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            busy, done, pass, fail;
  logic [AW-1:0]   avm_address;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_chipselect, avm_write, avm_debugaccess, avm_clken;
  logic [DW-1:0]   avm_writedata;
  logic [DW-1:0]   avm_readdata;

  logic [DW-1:0]   rom_mem [DEPTH];
  logic [DW-1:0]   img [DEPTH];
  bit              corrupt_en = 1'b0;

  logic [AW-1:0]   exp_wa_q[$];
  logic [DW-1:0]   exp_wd_q[$];
  logic [AW-1:0]   exp_ra_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ddr2_v11_0_p0_qsys_sequencer_rom_loader dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .word_count      (word_count),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail            (fail),
    .avm_address     (avm_address),
    .avm_byteenable  (avm_byteenable),
    .avm_chipselect  (avm_chipselect),
    .avm_write       (avm_write),
    .avm_debugaccess (avm_debugaccess),
    .avm_writedata   (avm_writedata),
    .avm_clken       (avm_clken),
    .avm_readdata    (avm_readdata)
  );

  // ROM model: debugaccess-gated writes, registered read data, optional bit-0 flip at address 2.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write && avm_debugaccess)
      rom_mem[avm_address] <= avm_writedata;
    if (avm_chipselect && !avm_write)
      avm_readdata <= rom_mem[avm_address] ^ ((corrupt_en && avm_address == 12'd2) ? 32'h1 : 32'h0);
  end

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({avm_chipselect, avm_write, avm_debugaccess, avm_clken, in_ready, busy, done, pass, fail} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_flags got=%b exp=000000000",
               {avm_chipselect, avm_write, avm_debugaccess, avm_clken, in_ready, busy, done, pass, fail});
    end
    n_cmp++;
    if (avm_address !== '0 || avm_writedata !== '0) begin
      n_err++;
      $display("FAIL reset_bus addr=%h wdata=%h exp=0/0", avm_address, avm_writedata);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (avm_clken !== 1'b0) begin
      n_err++;
      $display("FAIL clken_before_edge got=%b exp=0", avm_clken);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (avm_clken !== 1'b1) begin
      n_err++;
      $display("FAIL clken_after_edge got=%b exp=1", avm_clken);
    end
  endtask

  task automatic run_load(input string tag, input int n, input bit stall, input bit exp_pass,
                          input int exp_done, input bit poke_start);
    int nn;
    int widx;
    int cyc;
    int done_cyc;
    bit fire;
    bit poked;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    nn = (n > DEPTH) ? DEPTH : n;
    widx = 0;
    done_cyc = -1;
    poked = 1'b0;
    for (int i = 0; i < nn; i++) begin
      exp_wa_q.push_back(AW'(i));
      exp_wd_q.push_back(img[i]);
      exp_ra_q.push_back(AW'(i));
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    word_count = (AW+1)'(n);
    in_valid = 1'b0;
    cyc = 0;
    while (cyc < 2 * nn + 40 && done_cyc < 0) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      n_cmp++;
      if (busy !== (cyc >= 1)) begin
        n_err++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, busy, cyc >= 1);
      end
      if (avm_write) begin
        n_cmp++;
        if (!fire || exp_wa_q.size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected_write cyc=%0d addr=%h fire=%b", tag, cyc, avm_address, fire);
        end else begin
          ea = exp_wa_q.pop_front();
          ed = exp_wd_q.pop_front();
          if (avm_address !== ea || avm_writedata !== ed || avm_debugaccess !== 1'b1 || avm_chipselect !== 1'b1) begin
            n_err++;
            $display("FAIL %s write got addr=%h data=%h dbg=%b cs=%b exp addr=%h data=%h dbg=1 cs=1",
                     tag, avm_address, avm_writedata, avm_debugaccess, avm_chipselect, ea, ed);
          end
        end
      end else if (fire) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s missed_write cyc=%0d got write=0 exp write=1", tag, cyc);
      end
      if (avm_chipselect && !avm_write) begin
        n_cmp++;
        if (exp_ra_q.size() == 0 || exp_wa_q.size() != 0) begin
          n_err++;
          $display("FAIL %s unexpected_read cyc=%0d addr=%h", tag, cyc, avm_address);
        end else begin
          ea = exp_ra_q.pop_front();
          if (avm_address !== ea || avm_debugaccess !== 1'b0) begin
            n_err++;
            $display("FAIL %s read got addr=%h dbg=%b exp addr=%h dbg=0", tag, avm_address, avm_debugaccess, ea);
          end
        end
      end
      n_cmp++;
      if (avm_debugaccess !== avm_write || (avm_chipselect && avm_byteenable !== 4'hF)
          || (!avm_chipselect && (avm_write || avm_debugaccess))) begin
        n_err++;
        $display("FAIL %s strobes cyc=%0d cs=%b wr=%b dbg=%b be=%h", tag, cyc,
                 avm_chipselect, avm_write, avm_debugaccess, avm_byteenable);
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        n_cmp++;
        if (pass !== exp_pass || fail !== !exp_pass) begin
          n_err++;
          $display("FAIL %s result got pass=%b fail=%b exp pass=%b fail=%b", tag, pass, fail, exp_pass, !exp_pass);
        end
        if (exp_done >= 0) begin
          n_cmp++;
          if (cyc != exp_done) begin
            n_err++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", tag, cyc, exp_done);
          end
        end
      end
      @(posedge clk);
      #1;
      if (fire) widx++;
      start = 1'b0;
      if (poke_start && !poked && avm_chipselect && !avm_write) begin
        poked = 1'b1;
        start = 1'b1;
        word_count = (AW+1)'(5);
      end
      cyc++;
      in_valid = (widx < nn) && (!stall || cyc[0]);
      in_data = in_valid ? img[widx] : $urandom();
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (done_cyc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout no done after %0d cycles", tag, cyc);
    end else begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || pass !== exp_pass || fail !== !exp_pass) begin
        n_err++;
        $display("FAIL %s after_done got done=%b busy=%b pass=%b fail=%b exp 0 0 %b %b",
                 tag, done, busy, pass, fail, exp_pass, !exp_pass);
      end
    end
    n_cmp++;
    if (exp_wa_q.size() != 0 || exp_ra_q.size() != 0) begin
      n_err++;
      $display("FAIL %s leftover writes=%0d reads=%0d exp 0 0", tag, exp_wa_q.size(), exp_ra_q.size());
    end
    exp_wa_q.delete();
    exp_wd_q.delete();
    exp_ra_q.delete();
  endtask

  task automatic test_basic;
    for (int i = 0; i < 4; i++) img[i] = DW'(i + 1);
    run_load("basic", 4, 1'b0, 1'b1, 11, 1'b0);
  endtask

  task automatic test_stalled;
    for (int i = 0; i < 8; i++) img[i] = $urandom();
    run_load("stalled", 8, 1'b1, 1'b1, -1, 1'b0);
  endtask

  task automatic test_corruption;
    for (int i = 0; i < 4; i++) img[i] = $urandom();
    corrupt_en = 1'b1;
    run_load("corrupt", 4, 1'b0, 1'b0, 11, 1'b0);
    corrupt_en = 1'b0;
  endtask

  task automatic test_zero_and_ignored_start;
    run_load("zero", 0, 1'b0, 1'b1, 1, 1'b0);
    for (int i = 0; i < 6; i++) img[i] = $urandom();
    run_load("ignored_start", 6, 1'b0, 1'b1, 15, 1'b1);
  endtask

  task automatic test_full_depth;
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom();
    run_load("full", DEPTH, 1'b0, 1'b1, 2 * DEPTH + 3, 1'b0);
  endtask

  task automatic test_clamp;
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom();
    run_load("clamp", 5000, 1'b0, 1'b1, 2 * DEPTH + 3, 1'b0);
  endtask

  task automatic test_reset_mid;
    int widx;
    int cyc;
    bit fire;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    for (int i = 0; i < 8; i++) img[i] = $urandom();
    for (int i = 0; i < 3; i++) begin
      exp_wa_q.push_back(AW'(i));
      exp_wd_q.push_back(img[i]);
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    word_count = (AW+1)'(8);
    in_valid = 1'b0;
    widx = 0;
    cyc = 0;
    while (widx < 3 && cyc < 40) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      if (avm_write) begin
        n_cmp++;
        if (exp_wa_q.size() == 0) begin
          n_err++;
          $display("FAIL reset_mid unexpected_write addr=%h", avm_address);
        end else begin
          ea = exp_wa_q.pop_front();
          ed = exp_wd_q.pop_front();
          if (avm_address !== ea || avm_writedata !== ed) begin
            n_err++;
            $display("FAIL reset_mid write got %h/%h exp %h/%h", avm_address, avm_writedata, ea, ed);
          end
        end
      end
      @(posedge clk);
      #1;
      if (fire) widx++;
      start = 1'b0;
      cyc++;
      in_valid = 1'b1;
      in_data = img[widx];
    end
    n_cmp++;
    if (widx != 3 || avm_write !== 1'b1 || avm_address !== 12'd3) begin
      n_err++;
      $display("FAIL reset_mid pre_reset got widx=%0d wr=%b addr=%h exp 3 1 003", widx, avm_write, avm_address);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({avm_chipselect, avm_write, avm_debugaccess, avm_clken, in_ready, busy, done, pass, fail} !== 9'b0
        || avm_address !== '0 || avm_writedata !== '0) begin
      n_err++;
      $display("FAIL reset_mid async got flags=%b addr=%h wdata=%h exp all zero",
               {avm_chipselect, avm_write, avm_debugaccess, avm_clken, in_ready, busy, done, pass, fail},
               avm_address, avm_writedata);
    end
    n_cmp++;
    if (exp_wa_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid writes_seen missing=%0d exp 0", exp_wa_q.size());
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (avm_write !== 1'b0 || avm_chipselect !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid held got wr=%b cs=%b rdy=%b exp 0 0 0", avm_write, avm_chipselect, in_ready);
      end
    end
    in_valid = 1'b0;
    exp_wa_q.delete();
    exp_wd_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (avm_clken !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid release got clken=%b busy=%b exp 0 0", avm_clken, busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (avm_clken !== 1'b1 || avm_write !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid resume got clken=%b wr=%b exp 1 0", avm_clken, avm_write);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stalled;
    test_corruption;
    test_zero_and_ignored_start;
    test_reset_mid;
    test_full_depth;
    test_clamp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr2_v11_0_p0_qsys_sequencer_rom_loader.md
# ddr2_v11_0_p0_qsys_sequencer_rom_loader

Avalon-MM master that loads a sequencer ROM image into the 4096x32 sequencer ROM over its debug-write slave port, then reads the image back to verify it. It sits between a debug word stream (JTAG/UART bridge) and the ROM's `debugaccess` write path, so calibration code can be replaced without a full FPGA reconfiguration. It drives the ROM's fixed one-cycle read latency directly; there is no waitrequest.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: ROM word-address width.
- `DATA_WIDTH`, 32: ROM word width; byteenable width is `DATA_WIDTH/8`.
- `DEPTH`, 4096: ROM words; must equal `2**ADDR_WIDTH`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: single clock, shared with the ROM.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load; ignored while `busy`.
- `word_count` in `ADDR_WIDTH+1`: number of words to load, sampled on `start`; valid range 0..DEPTH.
- `in_valid` in 1: image word is available.
- `in_ready` out 1: loader accepts a word this cycle.
- `in_data` in `DATA_WIDTH`: image word.
- `busy` out 1: a load or verify is in progress.
- `done` out 1: one-cycle pulse at the end of a run.
- `pass` out 1: last run verified; held until the next `start`.
- `fail` out 1: last run mismatched; held until the next `start`.
- `avm_address` out `ADDR_WIDTH`: ROM word address.
- `avm_byteenable` out `DATA_WIDTH/8`: byte lanes; all ones whenever `avm_chipselect` is 1.
- `avm_chipselect` out 1: ROM select.
- `avm_write` out 1: write strobe.
- `avm_debugaccess` out 1: equals `avm_write`; the ROM gates writes with it.
- `avm_writedata` out `DATA_WIDTH`: write data.
- `avm_clken` out 1: ROM clock enable.
- `avm_readdata` in `DATA_WIDTH`: ROM read data, valid one cycle after the address is presented.

## Operation
- **IDLE.** On `start`:
  - `word_count` is latched into `cnt`; `addr`, `wsum` and `rsum` clear; `pass` and `fail` clear.
  - If `cnt`=0, go to DONE (verify passes trivially). Otherwise go to WRITE.
- **WRITE.**
  - `in_ready`=1, combinational on state.
  - On `in_valid&in_ready`, in the same cycle:
    - `avm_chipselect`=`avm_write`=`avm_debugaccess`=1, `avm_address`=`addr`, `avm_writedata`=`in_data`.
    - `wsum += in_data` (mod 2^DATA_WIDTH); `addr++`.
  - `in_valid` low inserts idle cycles; all avm strobes are 0 in those cycles.
  - After word `cnt-1` is accepted: `addr` returns to 0 and the FSM goes to READ.
- **READ.**
  - Every cycle: `avm_chipselect`=1, `avm_write`=0, `avm_address`=`addr`, `addr++`.
  - After the address `cnt-1` cycle, go to DRAIN.
- **DRAIN.** One cycle with the avm strobes at 0; captures the last read word.
- **Read-data accumulation.** `rsum += avm_readdata` in every cycle that follows a read-address cycle (a one-bit `rd_pend` flag tracks this).
- **CHECK.** One cycle: `pass`=(`wsum`==`rsum`), `fail`=!`pass`.
- **DONE.** `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- **Address arithmetic.**
  - `addr` is `ADDR_WIDTH+1` bits; the low `ADDR_WIDTH` bits drive `avm_address`.
  - `cnt`=DEPTH exercises the full range; `avm_address` wraps to 0 only at the end of a phase.
- **Counts above DEPTH** are clamped to DEPTH.

## Timing
- **Reset values:**
  - All avm strobes 0, `avm_address` 0, `avm_writedata` 0, `avm_clken` 0.
  - `in_ready`, `busy`, `done`, `pass`, `fail` all 0; state IDLE.
- **`avm_clken`** is a register that goes to 1 on the first clock after `reset_n` deasserts and stays 1.
- **Output registration:** all avm outputs except the WRITE-phase data path are registered. In WRITE, the strobes and `avm_writedata` are combinational from `in_valid`/`in_data`, so there is zero-cycle write latency per accepted word.
- **Cycle count:** for N words with `in_valid` held high:
  - WRITE takes N cycles and READ takes N cycles, then DRAIN, CHECK and DONE take 1 cycle each.
  - `done` is asserted 2N+3 cycles after the cycle following `start`.
- **`start` while busy** has no effect.
- **Reset mid-operation** aborts the run immediately. No further ROM writes occur, and a partial image may remain in the ROM.

## Structure
- Shared package holds:
  - State encoding enum (IDLE, WRITE, READ, DRAIN, CHECK, DONE).
  - `ROM_ADDR_WIDTH`=12, `ROM_DATA_WIDTH`=32, `ROM_DEPTH`=4096.
- Single module. No sub-module is needed, because the checksum is one adder per sum.

## Test plan
- **Basic load:** reset, `start` with `word_count`=4, words 0x1,0x2,0x3,0x4 with `in_valid` held high, ROM model correct:
  - Writes go to addresses 0..3 with `avm_debugaccess`=1.
  - Reads go to 0..3.
  - `done` arrives 11 cycles after the cycle following `start`, with `pass`=1.
- **Stalled input:** 8 words with `in_valid` toggling every cycle:
  - No avm strobe is asserted in idle cycles.
  - Addresses 0..7 are in order, and the run ends with `pass`=1.
- **Full depth:** `word_count`=4096 of random data:
  - Last write and last read are both at 0xFFF.
  - `avm_address` never wraps mid-phase, and the run ends with `pass`=1.
- **Corruption:** ROM model flips bit 0 at address 2 on readback → `fail`=1, `pass`=0, one `done` pulse.
- **Zero count and ignored start:** `word_count`=0 → `done` with `pass`=1 and no avm strobes. A second `start` during READ is ignored.
- **Reset mid-operation:** assert `reset_n`=0 during WRITE at word 3 → all outputs return to reset values that same cycle, asynchronously, and no further writes occur.
